// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the seven-segment display blocks.
// Holds the segment-vector type and the active-low hex glyph constants.
// Segment bit order is {g,f,e,d,c,b,a}. A 0 lights a segment.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_A     = 7'h08;
    localparam seg_t SEG_B     = 7'h03;
    localparam seg_t SEG_C     = 7'h46;
    localparam seg_t SEG_D     = 7'h21;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_F     = 7'h0E;
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg
// Combinational nibble to seven-segment glyph decoder (hex 0-F).
// Ports:
//   nibble - 4-bit value to display
//   glyph  - active-low segments {g,f,e,d,c,b,a}
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Full 16-entry table; the blank default is only there so every
    // path assigns the output.
    always_comb begin
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/multi_channel_seg_display.sv
// multi_channel_seg_display
// Multiplexed seven-segment driver for CHANNELS independent byte channels.
// Each channel owns two hex digits: digit 2k+1 shows the high nibble and
// digit 2k shows the low nibble. The digits are scanned one at a time, and
// each digit stays selected for SCAN_DIV clock cycles.
// Optional feature (macro SEG_ACTIVITY_DP_EN): each channel has an activity
// timer that is reloaded with ACT_HOLD on every capture. While the timer is
// nonzero, the decimal point of the channel's high digit is lit. When the
// macro is undefined, dp stays constant 1.
// Ports:
//   targetClk - single clock, rising edge
//   reset     - synchronous, active-high
//   ch_valid  - per-channel capture strobe
//   ch_data   - channel k byte at [8k+7:8k]
//   seg       - active-low segments {g,f,e,d,c,b,a}, registered
//   an        - active-low digit enables, bit 0 rightmost, registered
//   dp        - active-low decimal point, registered
module multi_channel_seg_display
    import seg_pkg::*;
#(
    parameter  int CHANNELS   = 2,
    parameter  int SCAN_DIV   = 100000,
    parameter  int ACT_HOLD   = 50000000,
    localparam int NUM_DIGITS = 2 * CHANNELS
)
(
    input  logic                    targetClk,
    input  logic                    reset,
    input  logic [CHANNELS-1:0]     ch_valid,
    input  logic [8*CHANNELS-1:0]   ch_data,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // An illegal configuration is rejected at elaboration, so it cannot
    // produce a silently broken scan.
    if (CHANNELS < 1 || CHANNELS > 4 || SCAN_DIV < 2 || ACT_HOLD < 1) begin : g_param_check
        $error("multi_channel_seg_display: parameter out of range");
    end

    logic [PRE_W-1:0]        prescale;
    logic [IDX_W-1:0]        digit_idx;
    logic [8*CHANNELS-1:0]   byte_regs;
    logic [3:0]              nibble;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    dp_next;

    // Prescaler and digit index. The index moves on only when the
    // prescaler wraps, so a data capture never disturbs scan timing.
    always_ff @(posedge targetClk) begin
        if (reset) begin
            prescale  <= '0;
            digit_idx <= '0;
        end else if (prescale == PRE_MAX) begin
            prescale  <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Per-channel byte capture. Each strobe bit is independent, and reset
    // takes priority over any strobe in the same cycle.
    always_ff @(posedge targetClk) begin
        if (reset) begin
            byte_regs <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (ch_valid[k]) begin
                    byte_regs[8*k +: 8] <= ch_data[8*k +: 8];
                end
            end
        end
    end

    // Digit d shows the nibble at bit offset 4*d, because channel k's byte
    // covers digits 2k (low nibble) and 2k+1 (high nibble).
    assign nibble = byte_regs[{digit_idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        an_next = ~(NUM_DIGITS'(1) << digit_idx);
    end

`ifdef SEG_ACTIVITY_DP_EN
    localparam int ACT_W = $clog2(ACT_HOLD + 1);

    logic [ACT_W-1:0] act_cnt [CHANNELS];

    // Activity timers. A timer reloads on every strobe, even when it is
    // already running, and stops counting when it reaches zero.
    always_ff @(posedge targetClk) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                act_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (ch_valid[k]) begin
                    act_cnt[k] <= ACT_W'(ACT_HOLD);
                end else if (act_cnt[k] != '0) begin
                    act_cnt[k] <= act_cnt[k] - 1'b1;
                end
            end
        end
    end

    // The decimal point belongs only to each channel's high digit.
    always_comb begin
        dp_next = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (digit_idx == IDX_W'(2*k + 1) && act_cnt[k] != '0) begin
                dp_next = 1'b0;
            end
        end
    end
`else
    always_comb begin
        dp_next = 1'b1;
    end
`endif

    // Output registers. The outputs show the index and byte state of the
    // previous cycle, which is the one-cycle display latency.
    always_ff @(posedge targetClk) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= glyph;
            an  <= an_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_multi_channel_seg_display.sv
// tb_multi_channel_seg_display
// Directed bench for multi_channel_seg_display with CHANNELS=2,
// SCAN_DIV=4, ACT_HOLD=16. The bench drives and samples on the falling edge.
// After the n-th rising edge following reset release, the displayed digit
// index is ((n-1)/4) mod 4.
// The bench honours SEG_ACTIVITY_DP_EN when choosing the expected dp values.
module tb_multi_channel_seg_display;

    logic        targetClk;
    logic        reset;
    logic [1:0]  ch_valid;
    logic [15:0] ch_data;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int vectors;
    int miscompares;

`ifdef SEG_ACTIVITY_DP_EN
    localparam logic DP_HOLD = 1'b0;
`else
    localparam logic DP_HOLD = 1'b1;
`endif

    multi_channel_seg_display #(
        .CHANNELS (2),
        .SCAN_DIV (4),
        .ACT_HOLD (16)
    ) dut (
        .targetClk (targetClk),
        .reset     (reset),
        .ch_valid  (ch_valid),
        .ch_data   (ch_data),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    initial targetClk = 1'b0;
    always #5 targetClk = ~targetClk;

    task automatic applyStimulus(input logic rst, input logic [1:0] valid, input logic [15:0] data);
        reset    = rst;
        ch_valid = valid;
        ch_data  = data;
    endtask

    // One step covers one rising edge and ends on the following falling edge.
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge targetClk);
            @(negedge targetClk);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    task automatic checkDisplay(input string tag, input logic [6:0] exp_seg, input logic [3:0] exp_an, input logic exp_dp);
        checkOutput({tag, ".seg"}, 32'(seg), 32'(exp_seg));
        checkOutput({tag, ".an"},  32'(an),  32'(exp_an));
        checkOutput({tag, ".dp"},  32'(dp),  32'(exp_dp));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Hold reset for 3 cycles, then release and follow the scan.
        applyStimulus(1'b1, 2'b00, 16'h0000);
        stepCycles(3);
        checkDisplay("reset", 7'h7F, 4'b1111, 1'b1);
        applyStimulus(1'b0, 2'b00, 16'h0000);
        stepCycles(1);
        checkDisplay("e1", 7'h40, 4'b1110, 1'b1);
        stepCycles(3);
        checkOutput("e4.an", 32'(an), 32'(4'b1110));
        stepCycles(1);
        checkDisplay("e5", 7'h40, 4'b1101, 1'b1);
        stepCycles(4);
        checkOutput("e9.an", 32'(an), 32'(4'b1011));
        stepCycles(4);
        checkOutput("e13.an", 32'(an), 32'(4'b0111));
        stepCycles(4);
        checkOutput("e17.an", 32'(an), 32'(4'b1110));

        // Capture both channels in one cycle: digits 0..3 show F,5,5,A.
        applyStimulus(1'b0, 2'b11, 16'hA55F);
        stepCycles(1);
        checkOutput("e18.seg_latency", 32'(seg), 32'(7'h40));
        applyStimulus(1'b0, 2'b00, 16'h0000);
        stepCycles(1);
        checkDisplay("e19.d0", 7'h0E, 4'b1110, 1'b1);
        stepCycles(2);
        checkDisplay("e21.d1", 7'h12, 4'b1101, 1'b1);
        stepCycles(4);
        checkDisplay("e25.d2", 7'h12, 4'b1011, 1'b1);
        stepCycles(4);
        checkDisplay("e29.d3", 7'h08, 4'b0111, 1'b1);
        stepCycles(4);
        checkDisplay("e33.d0", 7'h0E, 4'b1110, 1'b1);

        // Update channel 0 in the middle of digit 0's slot.
        applyStimulus(1'b0, 2'b01, 16'h0027);
        stepCycles(1);
        checkOutput("e34.seg_old", 32'(seg), 32'(7'h0E));
        applyStimulus(1'b0, 2'b00, 16'h0000);
        stepCycles(1);
        checkDisplay("e35.mid", 7'h78, 4'b1110, 1'b1);
        stepCycles(1);
        checkOutput("e36.an", 32'(an), 32'(4'b1110));
        stepCycles(1);
        checkDisplay("e37.d1", 7'h24, 4'b1101, 1'b1);

        // Activity hold on channel 1 (captured at e38), re-pulsed at e48.
        applyStimulus(1'b0, 2'b10, 16'hA500);
        stepCycles(1);
        checkOutput("e38.dp", 32'(dp), 32'(1'b1));
        applyStimulus(1'b0, 2'b00, 16'h0000);
        stepCycles(6);
        checkDisplay("e44.d2", 7'h12, 4'b1011, 1'b1);
        stepCycles(1);
        checkDisplay("e45.d3", 7'h08, 4'b0111, DP_HOLD);
        stepCycles(2);
        applyStimulus(1'b0, 2'b10, 16'hA500);
        stepCycles(1);
        checkDisplay("e48.d3", 7'h08, 4'b0111, DP_HOLD);
        applyStimulus(1'b0, 2'b00, 16'h0000);
        stepCycles(13);
        checkDisplay("e61.extend", 7'h08, 4'b0111, DP_HOLD);
        stepCycles(3);
        checkDisplay("e64.extend", 7'h08, 4'b0111, DP_HOLD);
        stepCycles(1);
        checkDisplay("e65.d0", 7'h78, 4'b1110, 1'b1);
        stepCycles(12);
        checkDisplay("e77.expired", 7'h08, 4'b0111, 1'b1);

        // Arm activity, then assert reset together with a channel 0 strobe.
        applyStimulus(1'b0, 2'b10, 16'hA500);
        stepCycles(1);
        applyStimulus(1'b1, 2'b01, 16'h003C);
        stepCycles(2);
        checkDisplay("rst2", 7'h7F, 4'b1111, 1'b1);
        applyStimulus(1'b0, 2'b00, 16'h0000);
        stepCycles(1);
        checkDisplay("rst2.e1", 7'h40, 4'b1110, 1'b1);
        stepCycles(4);
        checkDisplay("rst2.e5", 7'h40, 4'b1101, 1'b1);
        stepCycles(8);
        checkDisplay("rst2.e13", 7'h40, 4'b0111, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
